// File: rtl/wb_pkg.sv
// Shared writeback types: result uop layout and the sqN age compare
// used by every flush path (divider FIFO, incoming divider, ALU).
package wb_pkg;

    localparam int SQN_W = 7;

    typedef struct packed {
        logic             valid;
        logic [31:0]      result;
        logic [6:0]       tagDst;
        logic [4:0]       nmDst;
        logic [SQN_W-1:0] sqN;
        logic [2:0]       flags;
    } res_uop_t;

    // a is younger than b when the wrapped difference is strictly positive
    function automatic logic is_younger(input logic [SQN_W-1:0] a,
                                        input logic [SQN_W-1:0] b);
        logic [SQN_W-1:0] diff;
        diff = a - b;
        return $signed(diff) > 0;
    endfunction

endpackage

// File: rtl/wb_res_fifo.sv
// Divider result FIFO. Each entry carries its own valid bit so a branch
// flush can kill younger entries in place; killed entries keep their slot
// and drain through the normal pop path.
module wb_res_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  res_uop_t                 push_uop,
    input  logic                     pop,
    input  logic                     squash,
    input  logic [SQN_W-1:0]         squash_sqn,
    output res_uop_t                 head_uop,
    output logic                     head_vld,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     dropped
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    res_uop_t         mem [DEPTH];
    logic [DEPTH-1:0] vld;
    logic [PW-1:0]    rd;
    logic [PW-1:0]    wr;
    logic             full;
    logic             do_pop;
    logic             do_push;

    assign full     = (count == CW'(DEPTH));
    assign do_pop   = pop && (count != '0);
    // a pop in the same cycle frees the slot, so a full FIFO can still accept
    assign do_push  = push && (!full || do_pop);
    assign dropped  = push && full && !do_pop;
    assign head_uop = mem[rd];
    assign head_vld = vld[rd];

    // storage, squash, pointers and occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
            vld   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (squash && vld[i] && is_younger(mem[i].sqN, squash_sqn)) begin
                    vld[i] <= 1'b0;
                end
            end
            if (do_pop) begin
                vld[rd] <= 1'b0;
                rd      <= rd + 1'b1;
            end
            // push last: with full+pop, wr == rd and the new entry must stay valid
            if (do_push) begin
                mem[wr] <= push_uop;
                vld[wr] <= 1'b1;
                wr      <= wr + 1'b1;
            end
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

`ifndef SYNTHESIS
    // flag a divider result lost to a full FIFO
    always_ff @(posedge clk) begin
        if (rst) begin
            assert (!dropped)
                else $warning("wb_res_fifo: divider result dropped, FIFO full");
        end
    end
`endif

endmodule

// File: rtl/div_wb_merge.sv
// Merges the single-cycle ALU stream and the divider result pulse onto one
// registered writeback port. ALU has priority; divider results wait in
// wb_res_fifo. Branch flushes squash younger results everywhere.
// Optional statistics (conflict counter, FIFO high-water mark) are built
// when DIV_WB_STATS_EN is defined.
module div_wb_merge
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int SQN_W = wb_pkg::SQN_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     IN_branchValid,
    input  logic [SQN_W-1:0]         IN_branchSqN,
    input  res_uop_t                 IN_alu,
    input  res_uop_t                 IN_div,
    output res_uop_t                 OUT_uop,
    output logic                     OUT_divStall,
    output logic                     OUT_overflow
`ifdef DIV_WB_STATS_EN
    ,
    output logic [31:0]              OUT_conflictCnt,
    output logic [$clog2(DEPTH):0]   OUT_maxOcc
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    res_uop_t        head_uop;
    res_uop_t        nxt_uop;
    logic            head_vld;
    logic            head_live;
    logic            alu_ok;
    logic            div_ok;
    logic            fifo_empty;
    logic            push;
    logic            pop;
    logic            dropped;
    logic [CW-1:0]   count;

    assign alu_ok     = IN_alu.valid && !(IN_branchValid && is_younger(IN_alu.sqN, IN_branchSqN));
    assign div_ok     = IN_div.valid && !(IN_branchValid && is_younger(IN_div.sqN, IN_branchSqN));
    // the head is judged against this cycle's flush before deciding what to pop
    assign head_live  = head_vld && !(IN_branchValid && is_younger(head_uop.sqN, IN_branchSqN));
    assign fifo_empty = (count == '0);

    wb_res_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_uop   (IN_div),
        .pop        (pop),
        .squash     (IN_branchValid),
        .squash_sqn (IN_branchSqN),
        .head_uop   (head_uop),
        .head_vld   (head_vld),
        .count      (count),
        .dropped    (dropped)
    );

    // writeback arbitration: ALU, then FIFO head, then divider bypass
    always_comb begin
        nxt_uop = '0;
        push    = 1'b0;
        pop     = 1'b0;
        if (alu_ok) begin
            nxt_uop = IN_alu;
            push    = div_ok;
        end else if (!fifo_empty) begin
            pop  = 1'b1;
            push = div_ok;
            if (head_live) begin
                nxt_uop = head_uop;
            end
        end else if (div_ok) begin
            nxt_uop = IN_div;
        end
    end

    // registered writeback port
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            OUT_uop <= '0;
        end else begin
            OUT_uop <= nxt_uop;
        end
    end

    // sticky overflow: only reset clears it
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            OUT_overflow <= 1'b0;
        end else if (dropped) begin
            OUT_overflow <= 1'b1;
        end
    end

    assign OUT_divStall = (count >= CW'(DEPTH - 1));

`ifdef DIV_WB_STATS_EN
    // saturating statistics on ALU/divider contention and FIFO occupancy
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            OUT_conflictCnt <= '0;
            OUT_maxOcc      <= '0;
        end else begin
            if (IN_alu.valid && (IN_div.valid || !fifo_empty) && (OUT_conflictCnt != '1)) begin
                OUT_conflictCnt <= OUT_conflictCnt + 32'd1;
            end
            if (count > OUT_maxOcc) begin
                OUT_maxOcc <= count;
            end
        end
    end
`endif

endmodule

// File: tb/tb_div_wb_merge.sv
`timescale 1ns/1ps
module tb_div_wb_merge;
    import wb_pkg::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       br_v;
    logic [6:0] br_sqn;
    res_uop_t   alu;
    res_uop_t   div;
    res_uop_t   out;
    logic       stall;
    logic       ovf;
`ifdef DIV_WB_STATS_EN
    logic [31:0] conflict_cnt;
    logic [2:0]  max_occ;
`endif

    always #5 clk = ~clk;

    div_wb_merge #(.DEPTH(DEPTH), .SQN_W(7)) dut (
        .clk            (clk),
        .rst            (rst),
        .IN_branchValid (br_v),
        .IN_branchSqN   (br_sqn),
        .IN_alu         (alu),
        .IN_div         (div),
        .OUT_uop        (out),
        .OUT_divStall   (stall),
        .OUT_overflow   (ovf)
`ifdef DIV_WB_STATS_EN
        ,
        .OUT_conflictCnt(conflict_cnt),
        .OUT_maxOcc     (max_occ)
`endif
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // reference model: ordered queue of pending divider results with a live flag
    typedef struct {
        res_uop_t u;
        bit       live;
    } ent_t;

    ent_t     q[$];
    res_uop_t m_out;
    bit       m_ovf;

    function automatic bit m_younger(input logic [6:0] a, input logic [6:0] b);
        int d;
        d = (int'(a) - int'(b) + 128) % 128;
        return (d >= 1) && (d <= 63);
    endfunction

    function automatic res_uop_t mk(input bit v, input logic [31:0] r, input logic [6:0] s);
        res_uop_t u;
        u.valid  = v;
        u.result = r;
        u.tagDst = 7'($urandom);
        u.nmDst  = 5'($urandom);
        u.sqN    = s;
        u.flags  = 3'($urandom);
        return u;
    endfunction

    task automatic idle();
        alu    = '0;
        div    = '0;
        br_v   = 1'b0;
        br_sqn = '0;
    endtask

    task automatic model_reset();
        q.delete();
        m_out = '0;
        m_ovf = 1'b0;
    endtask

    // advance one clock: update the model from the current inputs, then compare
    task automatic step(input string tag);
        bit       alu_ok;
        bit       div_ok;
        bit       do_pop;
        bit       do_push;
        res_uop_t nxt;
        ent_t     e;
        if (br_v) begin
            foreach (q[i]) begin
                if (m_younger(q[i].u.sqN, br_sqn)) q[i].live = 1'b0;
            end
        end
        alu_ok  = alu.valid && !(br_v && m_younger(alu.sqN, br_sqn));
        div_ok  = div.valid && !(br_v && m_younger(div.sqN, br_sqn));
        nxt     = '0;
        do_pop  = 1'b0;
        do_push = 1'b0;
        if (alu_ok) begin
            nxt     = alu;
            do_push = div_ok;
        end else if (q.size() > 0) begin
            do_pop  = 1'b1;
            do_push = div_ok;
            if (q[0].live) nxt = q[0].u;
        end else if (div_ok) begin
            nxt = div;
        end
        if (do_pop) void'(q.pop_front());
        if (do_push) begin
            if (q.size() < DEPTH) begin
                e.u    = div;
                e.live = 1'b1;
                q.push_back(e);
            end else begin
                m_ovf = 1'b1;
            end
        end
        m_out = nxt;
        @(posedge clk);
        #1;
        check({tag, "_uop"},   64'(out),               64'(m_out));
        check({tag, "_stall"}, 64'(stall),             64'(q.size() >= DEPTH - 1));
        check({tag, "_ovf"},   64'(ovf),               64'(m_ovf));
        check({tag, "_count"}, 64'(dut.u_fifo.count),  64'(q.size()));
    endtask

    task automatic pulse_reset();
        rst = 1'b0;
        #2;
        model_reset();
        rst = 1'b1;
    endtask

    initial begin
        idle();
        model_reset();
        rst = 1'b0;
        #12;
        check("rst_uop",   64'(out),              64'd0);
        check("rst_ovf",   64'(ovf),              64'd0);
        check("rst_count", 64'(dut.u_fifo.count), 64'd0);
        check("rst_stall", 64'(stall),            64'd0);
        rst = 1'b1;

        // bypass with an empty FIFO
        div = mk(1'b1, 32'h0000_0007, 7'd5);
        step("byp");
        check("byp_valid", 64'(out.valid),  64'd1);
        check("byp_res",   64'(out.result), 64'd7);
        check("byp_sqn",   64'(out.sqN),    64'd5);
        idle();

        // ALU/divider conflict
        alu = mk(1'b1, 32'hA1A1_0010, 7'd10);
        div = mk(1'b1, 32'h0000_0033, 7'd3);
        step("cfl1");
        check("cfl1_sqn",   64'(out.sqN),           64'd10);
        check("cfl1_count", 64'(dut.u_fifo.count), 64'd1);
        idle();
        step("cfl2");
        check("cfl2_valid", 64'(out.valid),  64'd1);
        check("cfl2_res",   64'(out.result), 64'h33);
        check("cfl2_sqn",   64'(out.sqN),    64'd3);

        // fill to full and overflow while the ALU owns the port
        for (int i = 1; i <= 5; i++) begin
            alu = mk(1'b1, $urandom, 7'(20 + i));
            div = mk(1'b1, 32'(100 + i), 7'(40 + i));
            step("full");
            if (i == 3) check("full_stall3", 64'(stall), 64'd1);
            if (i == 4) begin
                check("full_count4", 64'(dut.u_fifo.count), 64'd4);
                check("full_ovf4",   64'(ovf),              64'd0);
            end
            if (i == 5) check("full_ovf5", 64'(ovf), 64'd1);
        end
        idle();
        repeat (4) step("drain");
        check("drain_ovf_sticky", 64'(ovf), 64'd1);
        pulse_reset();
        check("ovf_cleared", 64'(ovf), 64'd0);

        // flush younger buffered entries
        alu = mk(1'b1, $urandom, 7'd1);
        div = mk(1'b1, 32'h44, 7'd4);
        step("flpush");
        alu = mk(1'b1, $urandom, 7'd2);
        div = mk(1'b1, 32'h99, 7'd9);
        step("flpush");
        alu = mk(1'b1, $urandom, 7'd3);
        div = mk(1'b1, 32'hCC, 7'd12);
        step("flpush");
        idle();
        br_v   = 1'b1;
        br_sqn = 7'd8;
        step("fl0");
        check("fl0_valid", 64'(out.valid), 64'd1);
        check("fl0_sqn",   64'(out.sqN),   64'd4);
        idle();
        step("fl1");
        check("fl1_valid", 64'(out.valid), 64'd0);
        step("fl2");
        check("fl2_valid", 64'(out.valid),          64'd0);
        check("fl2_count", 64'(dut.u_fifo.count), 64'd0);

        // age compare across sqN wrap
        br_v   = 1'b1;
        br_sqn = 7'd126;
        div    = mk(1'b1, 32'h2, 7'd2);
        step("wrap_young");
        check("wrap_young_valid", 64'(out.valid), 64'd0);
        br_v   = 1'b1;
        br_sqn = 7'd126;
        div    = mk(1'b1, 32'h78, 7'd120);
        step("wrap_old");
        check("wrap_old_valid", 64'(out.valid), 64'd1);
        check("wrap_old_sqn",   64'(out.sqN),   64'd120);
        idle();

        // asynchronous reset between clock edges
        alu = mk(1'b1, $urandom, 7'd50);
        div = mk(1'b1, $urandom, 7'd51);
        step("ar1");
        alu = mk(1'b1, $urandom, 7'd52);
        div = mk(1'b1, $urandom, 7'd53);
        step("ar2");
        check("ar_pre_count", 64'(dut.u_fifo.count), 64'd2);
        check("ar_pre_valid", 64'(out.valid),        64'd1);
        idle();
        #2;
        rst = 1'b0;
        #1;
        check("ar_valid", 64'(out.valid),          64'd0);
        check("ar_count", 64'(dut.u_fifo.count),   64'd0);
        model_reset();
        #2;
        rst = 1'b1;

        // randomized traffic, divider respects the stall
        for (int n = 0; n < 3000; n++) begin
            br_v   = ($urandom_range(7) == 0);
            br_sqn = 7'($urandom);
            alu    = mk($urandom_range(1) == 1, $urandom, 7'($urandom));
            if (q.size() < DEPTH - 1 && $urandom_range(2) == 0)
                div = mk(1'b1, $urandom, 7'($urandom));
            else
                div = '0;
            step("rnd");
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
